onchip_mem_agent: RTL

ONCHIP_MEM_AGENT -- requirements
Module: onchip_mem_agent

---
 rtl/onchip_mem_pkg.sv | 15 +
 rtl/onchip_mem_agent_if.sv | 31 +++
 rtl/onchip_mem_cmd_fifo.sv | 38 +++
 rtl/onchip_mem_agent.sv | 83 ++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg: shared types for the on-chip memory agent (command entry, op, FSM state).
// Entry fields are sized to the widest supported port; the agent uses the low ADDR_W/DATA_W bits.
package onchip_mem_pkg;
  localparam int MAX_ADDR_W = 32;
  localparam int MAX_DATA_W = 64;
  localparam int unsigned DEF_NUM_WORDS = 22500;
  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;
  typedef enum logic [1:0] {ACTIVE, DRAIN, FROZEN} state_e;
  typedef struct packed {
    op_e                       op;
    logic [MAX_ADDR_W-1:0]     addr;
    logic [MAX_DATA_W/8-1:0]   be;
    logic [MAX_DATA_W-1:0]     data;
  } cmd_t;
endpackage

// File: rtl/onchip_mem_agent_if.sv
// onchip_mem_agent_if: Avalon-MM slave request bus plus memory-side port of the agent.
interface onchip_mem_agent_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   s_address;
  logic                s_read;
  logic                s_write;
  logic [DATA_W/8-1:0] s_byteenable;
  logic [DATA_W-1:0]   s_writedata;
  logic                s_waitrequest;
  logic [DATA_W-1:0]   s_readdata;
  logic                s_readdatavalid;
  logic [ADDR_W-1:0]   m_address;
  logic [DATA_W/8-1:0] m_byteenable;
  logic [DATA_W-1:0]   m_writedata;
  logic                m_chipselect;
  logic                m_write;
  logic                m_clken;
  logic [DATA_W-1:0]   m_readdata;
  modport slave (
    input  s_address, s_read, s_write, s_byteenable, s_writedata, m_readdata,
    output s_waitrequest, s_readdata, s_readdatavalid,
    output m_address, m_byteenable, m_writedata, m_chipselect, m_write, m_clken
  );
  modport master (
    output s_address, s_read, s_write, s_byteenable, s_writedata, m_readdata,
    input  s_waitrequest, s_readdata, s_readdatavalid,
    input  m_address, m_byteenable, m_writedata, m_chipselect, m_write, m_clken
  );
endinterface

// File: rtl/onchip_mem_cmd_fifo.sv
// onchip_mem_cmd_fifo: power-of-two command FIFO; pointers wrap naturally, count is log2(DEPTH)+1 bits.
module onchip_mem_cmd_fifo
  import onchip_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  cmd_t                     din,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  cmd_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full    = count == (PW+1)'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_ok);
      rd_ptr <= rd_ptr + PW'(pop_ok);
      count  <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/onchip_mem_agent.sv
// onchip_mem_agent: queues Avalon-MM requests into on-chip memory with freeze/drain control.
// ONCHIP_MEM_AGENT_RDREG_EN adds an output register on read data (latency N+2).
module onchip_mem_agent
  import onchip_mem_pkg::*;
#(
  parameter int          ADDR_W     = 15,
  parameter int          DATA_W     = 32,
  parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  onchip_mem_agent_if.slave bus,
  input  logic              freeze,
  output logic              freeze_ack,
  output logic              err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state, state_nx;
  cmd_t push_cmd, head;
  logic full, empty, accept, issue, in_range, wait_req, rd_pend, rd_oor, drain_busy;
  logic [DATA_W-1:0] rd_data;
  logic [CW-1:0] count;
  logic unused_bits;
  assign wait_req = ~reset_n | full | (state != ACTIVE);
  assign accept   = (bus.s_read | bus.s_write) & ~wait_req;
  assign push_cmd = '{op:   bus.s_write ? OP_WRITE : OP_READ,
                      addr: MAX_ADDR_W'(bus.s_address),
                      be:   (MAX_DATA_W/8)'(bus.s_byteenable),
                      data: MAX_DATA_W'(bus.s_writedata)};
  onchip_mem_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(accept), .pop(issue), .din(push_cmd),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign issue    = ~empty;
  assign in_range = head.addr < NUM_WORDS;
  assign bus.s_waitrequest = wait_req;
  assign bus.m_address     = head.addr[ADDR_W-1:0];
  assign bus.m_byteenable  = head.be[DATA_W/8-1:0];
  assign bus.m_writedata   = head.data[DATA_W-1:0];
  assign bus.m_chipselect  = issue & in_range;
  assign bus.m_write       = issue & (head.op == OP_WRITE);
  assign bus.m_clken       = reset_n & (state != FROZEN);
  // out-of-range reads still answer in their slot, with zero data
  assign rd_data     = (rd_pend & ~rd_oor) ? bus.m_readdata : '0;
  assign freeze_ack  = state == FROZEN;
  assign unused_bits = ^{head, count};
`ifdef ONCHIP_MEM_AGENT_RDREG_EN
  logic [DATA_W-1:0] rd_q;
  logic rd_q_valid;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_q       <= '0;
      rd_q_valid <= 1'b0;
    end else begin
      rd_q       <= rd_data;
      rd_q_valid <= rd_pend;
    end
  assign bus.s_readdata      = rd_q;
  assign bus.s_readdatavalid = rd_q_valid;
  assign drain_busy          = rd_pend | rd_q_valid;
`else
  assign bus.s_readdata      = rd_data;
  assign bus.s_readdatavalid = rd_pend;
  assign drain_busy          = rd_pend;
`endif
  always_comb
    state_nx = (state == ACTIVE) ? (freeze ? DRAIN : ACTIVE) :
               !freeze ? ACTIVE :
               (state == DRAIN && empty && !drain_busy) ? FROZEN : state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= ACTIVE;
      err     <= 1'b0;
      rd_pend <= 1'b0;
      rd_oor  <= 1'b0;
    end else begin
      state   <= state_nx;
      err     <= err | (accept & bus.s_read & bus.s_write) | (issue & ~in_range);
      rd_pend <= issue & (head.op == OP_READ);
      rd_oor  <= ~in_range;
    end
endmodule
